// File: rtl/dsc_s2b_rx.sv
// Framed stochastic-to-binary receiver: counts ones of a unary bitstream over a
// frame (or until early stop) and returns count plus bits consumed.
module dsc_s2b_rx #(
  parameter int OUT_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 start,
  input  logic [OUT_WIDTH-1:0] frame_len,
  input  logic                 sn_in,
  input  logic                 stop,
  output logic                 busy,
  output logic [OUT_WIDTH-1:0] z,
  output logic [OUT_WIDTH-1:0] z_bits,
  output logic                 z_early,
  output logic                 z_valid,
  input  logic                 z_ready,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COUNT  = 2'd1,
    S_RESULT = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [OUT_WIDTH-1:0] ones_q, ones_d;
  logic [OUT_WIDTH-1:0] cyc_q, cyc_d;
  logic [OUT_WIDTH-1:0] len_q, len_d;
  logic [OUT_WIDTH-1:0] z_q, z_d;
  logic [OUT_WIDTH-1:0] z_bits_q, z_bits_d;
  logic                 z_early_q, z_early_d;

  logic [OUT_WIDTH-1:0] ones_inc;
  logic [OUT_WIDTH-1:0] cyc_inc;
  logic                 last_bit;

  assign ones_inc = ones_q + {{(OUT_WIDTH-1){1'b0}}, sn_in};
  assign cyc_inc  = cyc_q + {{(OUT_WIDTH-1){1'b0}}, 1'b1};
  assign last_bit = (cyc_inc == len_q) || stop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ones_q    <= '0;
      cyc_q     <= '0;
      len_q     <= '0;
      z_q       <= '0;
      z_bits_q  <= '0;
      z_early_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ones_q    <= ones_d;
      cyc_q     <= cyc_d;
      len_q     <= len_d;
      z_q       <= z_d;
      z_bits_q  <= z_bits_d;
      z_early_q <= z_early_d;
    end
  end

  // Result handshake: z_valid stays high with z/z_bits/z_early stable until a
  // cycle where z_valid && z_ready; the result is consumed on that clock edge.
  always_comb begin
    state_d   = state_q;
    ones_d    = ones_q;
    cyc_d     = cyc_q;
    len_d     = len_q;
    z_d       = z_q;
    z_bits_d  = z_bits_q;
    z_early_d = z_early_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (frame_len != '0) begin
            state_d = S_COUNT;
            len_d   = frame_len;
            ones_d  = '0;
            cyc_d   = '0;
          end else begin
            state_d   = S_RESULT;
            z_d       = '0;
            z_bits_d  = '0;
            z_early_d = 1'b0;
          end
        end
      end
      S_COUNT: begin
        if (en) begin
          if (last_bit) begin
            state_d   = S_RESULT;
            z_d       = ones_inc;
            z_bits_d  = cyc_inc;
            z_early_d = stop && (cyc_inc != len_q);
          end else begin
            ones_d = ones_inc;
            cyc_d  = cyc_inc;
          end
        end
      end
      S_RESULT: begin
        if (z_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == S_COUNT);
    z_valid     = (state_q == S_RESULT);
    z           = z_q;
    z_bits      = z_bits_q;
    z_early     = z_early_q;
    dbg_state_o = state_q;
  end

endmodule

// File: doc/dsc_s2b_rx.md
Name: dsc_s2b_rx

Overview:
- Frame-based stochastic-to-binary receiver: the decode end of a DSC serial link.
- An SNG/multiplier chain drives a unary bitstream `sn_in` for a framed interval. This block counts the ones over the frame and honours the early-shutoff indication from the producer.
- It returns a binary result plus the number of bits consumed, through a valid/ready result handshake.
- It replaces the free-running stoch2bin counter wherever a downstream consumer needs framed, handshaked results.

Parameters:
- OUT_WIDTH, 20, width of the ones count, frame length and bit-count fields (NUM_INPUTS*SNG_WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- en  input  1  global enable; when 0, COUNT state freezes (no bit consumed, no counter advance).
- start  input  1  frame start request; sampled only in IDLE.
- frame_len  input  OUT_WIDTH  frame length in bits; captured when start is accepted.
- sn_in  input  1  stochastic bitstream bit.
- stop  input  1  early shutoff (producer `ov`): the current bit is the last non-zero-possible bit.
- busy  output  1  high while in COUNT.
- z  output  OUT_WIDTH  ones count of the completed frame.
- z_bits  output  OUT_WIDTH  bits actually consumed in the completed frame.
- z_early  output  1  frame ended by stop before frame_len.
- z_valid  output  1  result available.
- z_ready  input  1  consumer accepts result.

Behaviour:
- States: IDLE, COUNT, RESULT. Registers: ones, cyc, len (OUT_WIDTH each).
- Reset (async): state=IDLE; ones=cyc=len=0; z=z_bits=0; z_early=0; z_valid=0; busy=0.
- IDLE:
  - start=1 and frame_len!=0 -> COUNT; len<=frame_len; ones<=0; cyc<=0. en is not required to accept start.
  - start=1 and frame_len==0 -> RESULT with z=0, z_bits=0, z_early=0.
  - start=0 -> stay.
- COUNT, en=0: hold all state; stop and sn_in are ignored.
- COUNT, en=1: the current sn_in is consumed.
  - ones_next=ones+sn_in; cyc_next=cyc+1.
  - If cyc_next==len or stop=1 -> RESULT. Register z=ones_next, z_bits=cyc_next, z_early=stop&(cyc_next!=len).
  - Otherwise ones<=ones_next; cyc<=cyc_next.
- Bit timing:
  - The first bit counted is the first COUNT cycle with en=1, i.e. the cycle after start acceptance.
  - The stop-cycle bit is counted.
  - stop on the last bit gives z_early=0.
- Latency: z_valid rises on the clock edge that consumes the final bit. It is visible in the following cycle.
- RESULT:
  - z_valid=1; z, z_bits and z_early are held stable.
  - z_valid&z_ready -> IDLE; z_valid drops the next cycle.
  - start is ignored in RESULT; no queuing.
  - z, z_bits and z_early retain their values after the handshake until the next frame completes.
- Arithmetic: ones<=cyc<=len<=2^OUT_WIDTH-1, so no overflow is possible; no saturation logic.
- busy=1 iff state==COUNT, registered with the state.
- frame_len changes after acceptance have no effect.
- Reset mid-frame: immediate abort to IDLE; no result produced.

Test Plan:
1. Directed frame:
   - Stimulus: frame_len=8, en=1, sn_in=1,0,1,1,0,0,1,0, no stop, z_ready=1.
   - Required: z_valid high the cycle after the 8th bit; z=4, z_bits=8, z_early=0; IDLE one cycle later.
2. Early shutoff:
   - Stimulus: frame_len=1023, sn_in all 1, stop asserted on the 5th consumed bit.
   - Required: z=5, z_bits=5, z_early=1.
3. en gating:
   - Stimulus: frame_len=4, bits 1,1,1,1, with en=0 for 3 cycles between bits 2 and 3, and sn_in=1 and stop=1 during the gap.
   - Required: z=4, z_bits=4, z_early=0.
4. Backpressure:
   - Stimulus: complete a frame with z_ready=0 for 10 cycles, pulsing start meanwhile.
   - Required: z_valid and z held for all 10 cycles; start ignored; after z_ready=1, IDLE with busy=0.
5. Zero-length frame:
   - Stimulus: frame_len=0 with start.
   - Required: z_valid next cycle with z=0, z_bits=0.
6. Full-scale and reset:
   - Full scale: frame_len=2^20-1 with sn_in all 1 -> z=z_bits=1048575.
   - Reset: assert rst mid-frame -> all outputs 0 immediately, no z_valid.
